instr_decode_stage: RTL

Buffered, pipelined MIPS instruction decode stage. Accepts fetched instruction/PC pairs through a valid/ready handshake into a DEPTH-entry FIFO. Presents the head entry fully decoded: fields, extended immediate, jump target, PC+4 and format class. Sits between fetch and register-read/hazard logic, and absorbs fetch/decode rate mismatch and stalls.

---
 rtl/mips_pkg.sv | 49 ++++
 rtl/instr_decode_stage_if.sv | 37 +++
 rtl/instr_field_decode.sv | 42 ++++
 rtl/instr_decode_stage.sv | 96 +++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, instruction-format class, field positions
// and the immediate-extension / format-classification rules.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2
  } fmt_e;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_W      = 16;
  localparam int JIDX_W     = 26;

  // Logical immediates are zero-extended, LUI loads the upper half, everything else sign-extends.
  function automatic logic [31:0] ext_imm(input logic [5:0] op, input logic [IMM_W-1:0] imm);
    logic [31:0] r;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: r = {16'h0000, imm};
      OP_LUI:                   r = {imm, 16'h0000};
      default:                  r = {{(32-IMM_W){imm[IMM_W-1]}}, imm};
    endcase
    return r;
  endfunction

  function automatic fmt_e fmt_of(input logic [5:0] op);
    fmt_e f;
    case (op)
      OP_RTYPE:    f = FMT_R;
      OP_J, OP_JAL: f = FMT_J;
      default:     f = FMT_I;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch-side and decode-side handshake bundle of the decode stage.
// Valid/ready: a beat transfers on a rising edge where valid && ready; the source holds
// its payload stable while valid && !ready, and ready may depend on nothing from valid.
interface instr_decode_stage_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_opcode;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [4:0]      out_shamt;
  logic [5:0]      out_funct;
  logic [31:0]     out_imm;
  logic [PC_W-1:0] out_jtarget;
  logic [PC_W-1:0] out_pc4;
  logic [1:0]      out_fmt;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
           out_funct, out_imm, out_jtarget, out_pc4, out_fmt
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
           out_funct, out_imm, out_jtarget, out_pc4, out_fmt
  );

endinterface

// File: rtl/instr_field_decode.sv
// Purely combinational MIPS field decoder: splits an instruction word and derives
// the extended immediate, jump target, PC+4 and format class.
module instr_field_decode
  import mips_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [31:0]     inst_i,
  input  logic [PC_W-1:0] pc_i,
  output logic [5:0]      opcode_o,
  output logic [4:0]      rs_o,
  output logic [4:0]      rt_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      shamt_o,
  output logic [5:0]      funct_o,
  output logic [31:0]     imm_o,
  output logic [PC_W-1:0] jtarget_o,
  output logic [PC_W-1:0] pc4_o,
  output fmt_e            fmt_o
);

  assign opcode_o = inst_i[OPCODE_LSB +: 6];
  assign rs_o     = inst_i[RS_LSB +: 5];
  assign rt_o     = inst_i[RT_LSB +: 5];
  assign rd_o     = inst_i[RD_LSB +: 5];
  assign shamt_o  = inst_i[SHAMT_LSB +: 5];
  assign funct_o  = inst_i[FUNCT_LSB +: 6];

  assign pc4_o = pc_i + PC_W'(4);
  assign imm_o = ext_imm(opcode_o, inst_i[IMM_W-1:0]);
  assign fmt_o = fmt_of(opcode_o);

  // The jump region comes from PC+4, not the instruction's own PC.
  generate
    if (PC_W > 28) begin : g_jt_region
      assign jtarget_o = {pc4_o[PC_W-1:28], inst_i[JIDX_W-1:0], 2'b00};
    end else begin : g_jt_flat
      assign jtarget_o = {inst_i[JIDX_W-1:0], 2'b00};
    end
  endgenerate

endmodule

// File: rtl/instr_decode_stage.sv
// Buffered decode stage: a DEPTH-entry instruction/PC FIFO whose head entry is
// decoded combinationally onto the output bundle.
module instr_decode_stage
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 flush,
  instr_decode_stage_if.slave ifc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     inst_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q   [DEPTH];

  logic full, empty, push, pop;
  fmt_e head_fmt;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // No pass-through: a full FIFO refuses a push even while it pops.
  assign push  = ifc.in_valid && !full && !flush;
  assign pop   = ifc.out_ready && !empty && !flush;

  assign ifc.in_ready  = !full;
  assign ifc.out_valid = !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the decoded outputs are defined while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (push) begin
      inst_mem_q[wr_ptr_q] <= ifc.in_inst;
      pc_mem_q[wr_ptr_q]   <= ifc.in_pc;
    end
  end

  instr_field_decode #(
    .PC_W(PC_W)
  ) u_field_decode (
    .inst_i   (inst_mem_q[rd_ptr_q]),
    .pc_i     (pc_mem_q[rd_ptr_q]),
    .opcode_o (ifc.out_opcode),
    .rs_o     (ifc.out_rs),
    .rt_o     (ifc.out_rt),
    .rd_o     (ifc.out_rd),
    .shamt_o  (ifc.out_shamt),
    .funct_o  (ifc.out_funct),
    .imm_o    (ifc.out_imm),
    .jtarget_o(ifc.out_jtarget),
    .pc4_o    (ifc.out_pc4),
    .fmt_o    (head_fmt)
  );

  assign ifc.out_fmt = head_fmt;

endmodule
